// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer: word width and
// the sequencer FSM state encoding.
package i2c_cfg_sequencer_pkg;

  localparam int I2C_WORD_W = 24;
  localparam int ROM_IDX_W  = 6;
  localparam int ROM_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_DROP,
    ST_ARM,
    ST_CHECK,
    ST_DONE
  } cfg_state_t;

endpackage

// File: rtl/i2c_cfg_rom.sv
// Codec/video-decoder register table: idx -> {sub_addr, data}.
// Entries past the end of the table read as zero.
module i2c_cfg_rom
  import i2c_cfg_sequencer_pkg::*;
(
  input  logic [ROM_IDX_W-1:0]  idx,
  output logic [ROM_WORD_W-1:0] word
);

  always_comb begin
    word = 16'h0000;
    case (idx)
      // audio codec
      6'd0:  word = 16'h001A;  6'd1:  word = 16'h021A;  6'd2:  word = 16'h047B;
      6'd3:  word = 16'h067B;  6'd4:  word = 16'h08F8;  6'd5:  word = 16'h0A06;
      6'd6:  word = 16'h0C00;  6'd7:  word = 16'h0E01;  6'd8:  word = 16'h1002;
      6'd9:  word = 16'h1201;
      // video decoder
      6'd10: word = 16'h1500;  6'd11: word = 16'h1741;  6'd12: word = 16'h3A16;
      6'd13: word = 16'h5004;  6'd14: word = 16'hC305;  6'd15: word = 16'hC480;
      6'd16: word = 16'h0E80;  6'd17: word = 16'h5020;  6'd18: word = 16'h5218;
      6'd19: word = 16'h58ED;  6'd20: word = 16'h77C5;  6'd21: word = 16'h7C93;
      6'd22: word = 16'h7D00;  6'd23: word = 16'hD048;  6'd24: word = 16'hD5A0;
      6'd25: word = 16'hD7EA;  6'd26: word = 16'hE43E;  6'd27: word = 16'hEA0F;
      6'd28: word = 16'h3112;  6'd29: word = 16'h3281;  6'd30: word = 16'h3384;
      6'd31: word = 16'h37A0;  6'd32: word = 16'hE580;  6'd33: word = 16'hE603;
      6'd34: word = 16'hE785;  6'd35: word = 16'h5000;  6'd36: word = 16'h5100;
      6'd37: word = 16'h0050;  6'd38: word = 16'h1000;  6'd39: word = 16'h0402;
      6'd40: word = 16'h0B00;  6'd41: word = 16'h0A20;  6'd42: word = 16'h1100;
      6'd43: word = 16'h2B00;  6'd44: word = 16'h2C8C;  6'd45: word = 16'h2DF2;
      6'd46: word = 16'h2EEE;  6'd47: word = 16'h2FF4;  6'd48: word = 16'h30D2;
      6'd49: word = 16'h0E05;  6'd50: word = 16'h1300;
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the register table into the I2C byte-write controller after reset,
// retrying NACKed writes, and generates the controller's slow clock.
//
// state   | meaning
// POWERUP | wait POWERUP_TICKS controller-clock periods
// DROP    | GO low, latch next table word
// ARM     | GO high, wait for END to go low then high
// CHECK   | GO low, evaluate ACK, advance or retry
// DONE    | table finished, idle until REINIT
module i2c_cfg_sequencer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int          CLK_DIV       = 1250,
  parameter int          POWERUP_TICKS = 1024,
  parameter logic [7:0]  SLAVE_ADDR    = 8'h34,
  parameter int          LUT_SIZE      = 51,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  REINIT,
  output logic                  I2C_CTRL_CLK,
  output logic [I2C_WORD_W-1:0] I2C_DATA,
  output logic                  GO,
  input  logic                  END,
  input  logic                  ACK,
  output logic [ROM_IDX_W-1:0]  LUT_INDEX,
  output logic                  CFG_DONE,
  output logic                  CFG_ERR
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PU_W    = (POWERUP_TICKS > 1) ? $clog2(POWERUP_TICKS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PU_W-1:0] PU_LOAD = PU_W'(POWERUP_TICKS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic                  ctrl_clk;
  logic                  div_wrap;
  logic                  fall_stb;
  cfg_state_t            state;
  logic [PU_W-1:0]       pu_cnt;
  logic [RETRY_W-1:0]    retry;
  logic                  armed;
  logic [ROM_IDX_W-1:0]  idx;
  logic [ROM_IDX_W-1:0]  idx_nxt;
  logic [ROM_WORD_W-1:0] rom_word;
  logic                  go;
  logic [I2C_WORD_W-1:0] i2c_data;
  logic                  cfg_done;
  logic                  cfg_err;

  i2c_cfg_rom u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_stb = div_wrap & ctrl_clk;
  assign idx_nxt  = idx + 6'd1;

  // Free-running divider; REINIT deliberately leaves it alone.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_cnt  <= '0;
      ctrl_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      ctrl_clk <= ~ctrl_clk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_POWERUP;
      pu_cnt   <= PU_LOAD;
      retry    <= '0;
      armed    <= 1'b0;
      idx      <= '0;
      go       <= 1'b0;
      i2c_data <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (REINIT) begin
      state    <= ST_POWERUP;
      pu_cnt   <= PU_LOAD;
      retry    <= '0;
      armed    <= 1'b0;
      idx      <= '0;
      go       <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (fall_stb) begin
      case (state)
        ST_POWERUP: begin
          if (pu_cnt == '0) state <= ST_DROP;
          else              pu_cnt <= pu_cnt - PU_W'(1);
        end
        ST_DROP: begin
          i2c_data <= {SLAVE_ADDR, rom_word};
          armed    <= 1'b0;
          go       <= 1'b1;
          state    <= ST_ARM;
        end
        ST_ARM: begin
          // END stays high from the previous transfer (or from reset) until the
          // controller starts; only a high after a seen low means completion.
          if (!END) begin
            armed <= 1'b1;
          end else if (armed) begin
            go    <= 1'b0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (ACK && retry != RETRY_W'(MAX_RETRY)) begin
            retry <= retry + RETRY_W'(1);
            state <= ST_DROP;
          end else begin
            if (ACK) cfg_err <= 1'b1;
            retry <= '0;
            idx   <= idx_nxt;
            if (idx_nxt == 6'(LUT_SIZE)) begin
              cfg_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state    <= ST_DROP;
            end
          end
        end
        ST_DONE: begin
          go       <= 1'b0;
          cfg_done <= 1'b1;
        end
        default: state <= ST_POWERUP;
      endcase
    end
  end

  assign I2C_CTRL_CLK = ctrl_clk;
  assign I2C_DATA     = i2c_data;
  assign GO           = go;
  assign LUT_INDEX    = idx;
  assign CFG_DONE     = cfg_done;
  assign CFG_ERR      = cfg_err;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: behavioural byte-write controller plus a
// per-entry NACK plan; expected transfer lists are built from the plan.
module tb_i2c_cfg_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int PU_TICKS = 8;
  localparam int LUT_SIZE = 3;
  localparam int MAX_RTY  = 3;
  localparam int XFER_LEN = 33;
  localparam int PERIOD   = 2 * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reinit = 1'b0;
  logic        ctrl_clk;
  logic [23:0] i2c_data;
  logic        go;
  logic        ctl_end = 1'b1;
  logic        ctl_ack = 1'b0;
  logic [5:0]  lut_index;
  logic        cfg_done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom_exp [LUT_SIZE] = '{16'h001A, 16'h021A, 16'h047B};
  int          plan_n [LUT_SIZE];
  int          nack_left [LUT_SIZE];
  logic [23:0] issued [$];
  int          step = 0;
  bit          busy = 1'b0;
  logic [23:0] cur_word;

  int          gap = 0;
  int          min_gap = 1000000;
  bit          seen_go = 1'b0;
  bit          prev_go = 1'b0;
  logic [23:0] prev_data = '0;
  int          data_glitch = 0;

  i2c_cfg_sequencer #(
    .CLK_DIV(CLK_DIV), .POWERUP_TICKS(PU_TICKS), .SLAVE_ADDR(8'h34),
    .LUT_SIZE(LUT_SIZE), .MAX_RETRY(MAX_RTY)
  ) dut (
    .CLOCK(clock), .RESET(reset), .REINIT(reinit), .I2C_CTRL_CLK(ctrl_clk),
    .I2C_DATA(i2c_data), .GO(go), .END(ctl_end), .ACK(ctl_ack),
    .LUT_INDEX(lut_index), .CFG_DONE(cfg_done), .CFG_ERR(cfg_err)
  );

  always #5 clock = ~clock;

  function automatic int entry_of(input logic [23:0] w);
    for (int e = 0; e < LUT_SIZE; e++)
      if (w == {8'h34, rom_exp[e]}) return e;
    return -1;
  endfunction

  // Controller model: restarts on GO low, runs XFER_LEN ticks, then END=1.
  always @(posedge ctrl_clk or negedge reset) begin
    if (!reset) begin
      step = 0; busy = 1'b0; ctl_end = 1'b1; ctl_ack = 1'b0;
    end else if (!go) begin
      step = 0; busy = 1'b0;
    end else if (!busy && step == 0) begin
      busy = 1'b1; step = 1; ctl_end = 1'b0;
      cur_word = i2c_data;
      issued.push_back(i2c_data);
    end else if (busy) begin
      step++;
      if (step == XFER_LEN) begin
        int e;
        busy = 1'b0; ctl_end = 1'b1;
        e = entry_of(cur_word);
        if (e >= 0 && nack_left[e] > 0) begin
          ctl_ack = 1'b1; nack_left[e]--;
        end else begin
          ctl_ack = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      gap = 0; seen_go = 1'b0; prev_go = 1'b0;
    end else begin
      if (!go) begin
        gap++;
      end else if (!prev_go) begin
        if (seen_go && gap < min_gap) min_gap = gap;
        seen_go = 1'b1; gap = 0;
      end else if (i2c_data != prev_data) begin
        data_glitch++;
      end
      prev_go = go;
      prev_data = i2c_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_plan(input int n0, input int n1, input int n2);
    plan_n[0] = n0; plan_n[1] = n1; plan_n[2] = n2;
    for (int e = 0; e < LUT_SIZE; e++) nack_left[e] = plan_n[e];
    issued.delete();
    min_gap = 1000000;
    data_glitch = 0;
  endtask

  task automatic start_reset();
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic start_reinit();
    @(negedge clock); reinit = 1'b1;
    @(negedge clock); reinit = 1'b0;
  endtask

  task automatic count_go_high(input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (go) highs++;
    end
  endtask

  task automatic finish_plan(input string tag);
    logic [23:0] exp_q [$];
    bit exp_err = 1'b0;
    int cyc = 0;
    for (int e = 0; e < LUT_SIZE; e++) begin
      int att = (plan_n[e] > MAX_RTY) ? MAX_RTY + 1 : plan_n[e] + 1;
      if (plan_n[e] > MAX_RTY) exp_err = 1'b1;
      for (int a = 0; a < att; a++) exp_q.push_back({8'h34, rom_exp[e]});
    end
    while (!cfg_done && cyc < 20000) begin
      @(negedge clock); cyc++;
    end
    check_eq({tag, "_done"}, cfg_done, 1);
    check_eq({tag, "_err"}, cfg_err, exp_err);
    check_eq({tag, "_index"}, lut_index, LUT_SIZE);
    check_eq({tag, "_go_idle"}, go, 0);
    check_eq({tag, "_n_xfers"}, issued.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
      check_eq($sformatf("%s_xfer%0d", tag, i), issued[i], exp_q[i]);
    check_eq({tag, "_go_gap_ok"}, (min_gap >= PERIOD), 1);
    check_eq({tag, "_data_stable"}, data_glitch, 0);
  endtask

  initial begin
    int highs;
    int cyc;

    // reset values and power-up delay
    set_plan(0, 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_ctrl_clk", ctrl_clk, 0);
    check_eq("rst_go", go, 0);
    check_eq("rst_data", i2c_data, 0);
    check_eq("rst_index", lut_index, 0);
    check_eq("rst_done", cfg_done, 0);
    check_eq("rst_err", cfg_err, 0);
    reset = 1'b1;
    count_go_high(PU_TICKS * PERIOD, highs);
    check_eq("powerup_go_low", highs, 0);
    cyc = 0;
    while (!go && cyc < 200) begin
      @(negedge clock); cyc++;
    end
    check_eq("first_go", go, 1);
    check_eq("first_data", i2c_data, {8'h34, rom_exp[0]});
    repeat (4 * PERIOD) @(negedge clock);
    check_eq("pre_end_no_advance", lut_index, 0);
    check_eq("pre_end_go_held", go, 1);
    finish_plan("all_ack");

    // entry 1 NACKed twice, then accepted
    set_plan(0, 2, 0);
    start_reinit();
    finish_plan("nack_twice");

    // entry 1 never accepted
    set_plan(0, 99, 0);
    start_reinit();
    finish_plan("nack_always");

    // REINIT in the middle of entry 2
    set_plan(0, 99, 0);
    start_reinit();
    cyc = 0;
    while (!(go && lut_index == 2) && cyc < 20000) begin
      @(negedge clock); cyc++;
    end
    check_eq("reinit_reach_idx2", lut_index, 2);
    check_eq("reinit_err_before", cfg_err, 1);
    repeat (10 * PERIOD) @(negedge clock);
    set_plan(0, 0, 0);
    reinit = 1'b1;
    @(posedge clock); #1;
    check_eq("reinit_go", go, 0);
    check_eq("reinit_err_clr", cfg_err, 0);
    check_eq("reinit_index", lut_index, 0);
    @(negedge clock); reinit = 1'b0;
    count_go_high(PU_TICKS * PERIOD - 2, highs);
    check_eq("reinit_powerup_go_low", highs, 0);
    finish_plan("after_reinit");

    // asynchronous RESET while GO is high
    set_plan(1, 1, 1);
    start_reinit();
    cyc = 0;
    while (!(go && lut_index == 1) && cyc < 20000) begin
      @(negedge clock); cyc++;
    end
    check_eq("reset_reach_go", go, 1);
    repeat (20) @(negedge clock);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_ctrl_clk", ctrl_clk, 0);
    check_eq("arst_go", go, 0);
    check_eq("arst_data", i2c_data, 0);
    check_eq("arst_index", lut_index, 0);
    check_eq("arst_done", cfg_done, 0);
    check_eq("arst_err", cfg_err, 0);
    set_plan(0, 0, 0);
    @(negedge clock); reset = 1'b1;
    finish_plan("after_reset");

    // randomized NACK plans, restarted by RESET or REINIT
    for (int r = 0; r < 6; r++) begin
      set_plan($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) start_reset();
      else start_reinit();
      finish_plan($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
